// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 serial receiver with a one-cycle rx_done strobe and a framing-error flag.
// The stop bit is sampled near its end, so a following start bit needs no idle gap.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DIVISOR = 423
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            rx,
  output logic [DBIT-1:0] r_data,
  output logic            rx_done,
  output logic            frame_err
);
  localparam int DW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            rx_m, rx_s, tick;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      s_cnt;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;

  always_ff @(posedge pclk or negedge rst)
    if (!rst) {rx_m, rx_s} <= 2'b11;
    else      {rx_m, rx_s} <= {rx, rx_m};

  assign tick = div_cnt == DW'(DIVISOR - 1);

  always_ff @(posedge pclk or negedge rst)
    if (!rst) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + 1'b1;

  always_ff @(posedge pclk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n         <= '0;
      b         <= '0;
      r_data    <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        START:
          if (tick) begin
            if (s_cnt == 4'd7) begin
              state <= rx_s ? IDLE : DATA;
              s_cnt <= '0;
              n     <= '0;
            end else s_cnt <= s_cnt + 1'b1;
          end
        DATA:
          if (tick) begin
            if (s_cnt == 4'd15) begin
              b     <= {rx_s, b[DBIT-1:1]};
              s_cnt <= '0;
              if (n == NW'(DBIT - 1)) state <= STOP;
              else n <= n + 1'b1;
            end else s_cnt <= s_cnt + 1'b1;
          end
        STOP:
          if (tick) begin
            if (s_cnt == 4'(SB_TICK - 1)) begin
              r_data    <= b;
              frame_err <= ~rx_s;
              rx_done   <= 1'b1;
              state     <= IDLE;
            end else s_cnt <= s_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver for the game's link/control path. It oversamples the asynchronous `rx` line at 16x baud and de-serialises 8N1 frames, LSB first. For each frame it presents the byte on `r_data` with a one-cycle `rx_done` strobe. It sits directly upstream of the received-byte holding register, which captures `r_data` in the cycle `rx_done` is high.

Parameters:
- DBIT, 8: data bits per frame.
- SB_TICK, 16: oversample ticks spent in the stop bit (16 = 1 stop bit).
- DIVISOR, 423: pclk cycles per oversample tick. 65 MHz / (9600 * 16) ≈ 423. Benches use 4.

Ports:
- pclk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- rx, input, 1: serial line, asynchronous to pclk, idles high.
- r_data, output, DBIT: last received byte.
- rx_done, output, 1: one-pclk strobe; r_data/frame_err are valid in this same cycle.
- frame_err, output, 1: stop bit of the last frame was sampled low.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release via the clock edge):
  - state=IDLE; all counters 0; shift register 0.
  - r_data=0, rx_done=0, frame_err=0.
  - Both synchroniser flops = 1.
- Input sync:
  - rx passes through a 2-flop synchroniser to give rx_s.
  - Latency from rx to rx_s is 2 pclk. All decisions use rx_s.
- Tick generator:
  - Free-running counter 0..DIVISOR-1.
  - tick=1 for exactly one pclk when counter==DIVISOR-1, then the counter wraps to 0.
  - Runs in every state; it is not resynchronised to the start edge.
- FSM, with s_cnt (4 bit), n (log2 DBIT bits) and shift register b:
  - IDLE: when rx_s==0 → START, s_cnt=0. Evaluated every pclk, not only on tick.
  - START, on tick:
    - If s_cnt==7 (mid start bit): rx_s==0 → DATA with s_cnt=0, n=0. Otherwise → IDLE (glitch reject, no strobe).
    - Else s_cnt+1.
  - DATA, on tick:
    - If s_cnt==15: b={rx_s, b[DBIT-1:1]}, s_cnt=0. If n==DBIT-1 → STOP, else n+1.
    - Else s_cnt+1.
  - STOP, on tick:
    - If s_cnt==SB_TICK-1: r_data<=b, frame_err<=~rx_s, rx_done<=1, → IDLE.
    - Else s_cnt+1.
- rx_done:
  - High for exactly one pclk per completed frame, including frames with a framing error.
  - Deasserted on every other cycle.
- r_data and frame_err:
  - Registered on the same edge as rx_done.
  - Hold their value until the next completed frame. Never change while a frame is in flight.
- Framing error: the byte is still delivered. No recovery wait; the FSM returns to IDLE and re-arms on the next low level.
- Back-to-back frames: a start bit immediately after the stop sample is accepted with no idle gap required.
- Reset mid-frame: the frame is aborted with no strobe. After release the FSM waits in IDLE for rx_s low.
- Sampling points (from entry to START):
  - Data bit k is sampled ≈ (8+16(k+1)) ticks after entry.
  - Stop bit is sampled ≈ 8+16·DBIT+SB_TICK ticks after entry, i.e. near the end of the stop bit rather than its middle.
  - Timing tolerance is ±half a tick (start-edge detect uncertainty) plus the 2-cycle sync delay.

Test Plan:
- Reset, then rx held high for 1000 pclk → rx_done never asserts; r_data=0x00, frame_err=0.
- DIVISOR=4. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 64 pclk/bit → exactly one rx_done pulse 1 pclk wide; r_data=0xA5 and frame_err=0 in that cycle; r_data still 0xA5 1000 pclk later.
- rx low for 20 pclk (5 ticks), then high → FSM returns to IDLE; no rx_done; r_data unchanged.
- Send 0x3C with the stop bit driven 0, then return high → rx_done pulse with r_data=0x3C, frame_err=1. A following good 0x81 gives frame_err=0, r_data=0x81.
- Back-to-back 0x00 then 0xFF with no idle gap → two rx_done pulses, 10 bit-times apart; values 0x00 then 0xFF.
- Assert rst low during bit 4 of 0x55, release, then send 0x12 → no strobe for the aborted frame; next strobe carries r_data=0x12.
